// File: rtl/fetch_queue_stage_pkg.sv
// Shared constants for the fetch front-end.
package fetch_queue_stage_pkg;

    localparam int WORD_SIZE  = 32;
    localparam logic [WORD_SIZE-1:0] PC_INITIAL = '0;
    localparam int INSTR_STEP = 4;

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// Synchronous FIFO with flush; head is read combinationally.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       popData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wrPtr;
    logic [AW-1:0]               rdPtr;
    logic                        doPush;
    logic                        doPop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

    // Storage needs no reset; empty entries are never presented downstream
    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch front-end: PC, in-order imem requests, instruction queue to decode, redirect flush.
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int              XLEN     = WORD_SIZE,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(PC_INITIAL)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   pc;
    logic [CW-1:0]     liveCnt;
    logic [CW-1:0]     dropCnt;
    logic [CW-1:0]     queueCount;
    logic [CW-1:0]     tagCount;
    logic [CW+1:0]     inFlight;
    logic              queueEmpty, queueFull, tagEmpty, tagFull;
    logic [XLEN-1:0]   tagPc;
    logic [3*XLEN-1:0] headData;
    logic              reqFire, rspKeep, rspDrop, decFire;

    // Queue slots already promised (held + kept + discarded) bound new requests
    assign inFlight       = (CW+2)'(queueCount) + (CW+2)'(liveCnt) + (CW+2)'(dropCnt);
    assign imem_req_valid = !rst && !redirect_valid && (inFlight < (CW+2)'(DEPTH));
    assign imem_req_addr  = pc;
    assign reqFire        = imem_req_valid && imem_req_ready;

    assign rspKeep = imem_rsp_valid && !redirect_valid && dropCnt == '0 && !tagEmpty;
    assign rspDrop = imem_rsp_valid && dropCnt != '0;

    assign dec_valid = !queueEmpty && !redirect_valid;
    assign decFire   = dec_valid && dec_ready;
    assign {dec_instr, dec_pc, dec_pc_plus4} = queueEmpty ? '0 : headData;

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) tagFifo (
        .clk(clk), .rst(rst),
        .push(reqFire), .pushData(pc),
        .pop(rspKeep), .flush(redirect_valid),
        .popData(tagPc), .full(tagFull), .empty(tagEmpty), .count(tagCount)
    );

    fetch_fifo #(.WIDTH(3*XLEN), .DEPTH(DEPTH)) instrQueue (
        .clk(clk), .rst(rst),
        .push(rspKeep), .pushData({imem_rsp_data, tagPc, tagPc + XLEN'(INSTR_STEP)}),
        .pop(decFire), .flush(redirect_valid),
        .popData(headData), .full(queueFull), .empty(queueEmpty), .count(queueCount)
    );

    // PC and outstanding-request bookkeeping; a redirect turns every live request stale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            liveCnt <= '0;
            dropCnt <= '0;
        end else if (redirect_valid) begin
            pc      <= redirect_pc;
            liveCnt <= '0;
            dropCnt <= liveCnt + dropCnt
                       - CW'(imem_rsp_valid && (liveCnt != '0 || dropCnt != '0));
        end else begin
            if (reqFire) pc <= pc + XLEN'(INSTR_STEP);
            liveCnt <= liveCnt + CW'(reqFire) - CW'(rspKeep);
            dropCnt <= dropCnt - CW'(rspDrop);
        end
    end

    // Simulation-only protocol and consistency checks
    always @(posedge clk) begin
        if (!rst) begin
            if (imem_rsp_valid && liveCnt == '0 && dropCnt == '0)
                $error("fetch_queue_stage: imem response with no outstanding request");
            assert (tagCount == liveCnt) else $error("fetch_queue_stage: tag FIFO out of step");
            assert (!(reqFire && tagFull)) else $error("fetch_queue_stage: tag FIFO overflow");
            assert (!(rspKeep && queueFull && !decFire)) else $error("fetch_queue_stage: queue overflow");
        end
    end

endmodule
